trn_cpl_tx: RTL and testbench
=============================

// Module: trn_cpl_tx
// PURPOSE
//  Completion responder for the Virtex-5 PCIe endpoint TRN transmit interface.
//  Queues 1-DW register-read responses from the BAR decode logic.
//  Frames each response as a CplD TLP, or as a Cpl with UR status, and drives trn_td/trn_tsof_n/trn_teof_n.
//  Sits between the TRN-receive request decoder and the endpoint's transmit TRN port, all in the trn_clk domain.
// PARAMETERS
//  DEPTH  4  request FIFO entries; power of 2, >=2
// PORTS
//  trn_clk              in   1   sole clock; all logic rising-edge
//  trn_reset_n          in   1   synchronous active-low reset
//  trn_lnk_up_n         in   1   0 = link up
//  cfg_bus_number       in   8   completer ID bus field
//  cfg_device_number    in   5   completer ID device field
//  cfg_function_number  in   3   completer ID function field
//  req_valid            in   1   request offered
//  req_ready            out  1   FIFO can accept
//  req_info             in   48  {req_id[15:0],tag[7:0],tc[2:0],attr[1:0],lower_addr[6:0],byte_count[11:0]}
//  req_ur               in   1   1 = Unsupported Request (Cpl, no data)
//  req_data             in   32  read data DW (ignored when req_ur)
//  trn_td               out  64  TLP data; [63:32] first DW on the wire
//  trn_trem_n           out  8   remainder; 8'h00 = both DWs valid, 8'h0F = upper DW only
//  trn_tsof_n           out  1   start of frame
//  trn_teof_n           out  1   end of frame
//  trn_tsrc_rdy_n       out  1   source ready
//  trn_tsrc_dsc_n       out  1   tied 1
//  trn_terrfwd_n        out  1   tied 1
//  trn_tdst_rdy_n       in   1   core accepts beat when 0
//  trn_tdst_dsc_n       in   1   core discontinue when 0
//  trn_tbuf_av          in   4   buffer availability; bit 2 = completion
//  cpl_done             out  1   1-cycle pulse per completed TLP
//  dsc_count            out  8   saturating count of discontinued TLPs
// BEHAVIOUR
//  Reset (trn_reset_n=0 at an edge):
//   - FSM=IDLE; FIFO empty.
//   - tsof_n/teof_n/tsrc_rdy_n/tsrc_dsc_n/terrfwd_n=1; td=0; trem_n=8'hFF.
//   - cpl_done=0; dsc_count=0; req_ready=0 while in reset.
//  FIFO:
//   - req_ready = !full && !trn_lnk_up_n; push on req_valid&&req_ready.
//   - req_ready does not depend on a same-cycle pop, so a full FIFO never pushes.
//   - Simultaneous push+pop when not full is legal; occupancy is unchanged.
//  FSM states: IDLE -> BEAT0 -> BEAT1 -> IDLE. All outputs are registered.
//   - IDLE->BEAT0 when !empty && !trn_lnk_up_n && trn_tbuf_av[2].
//   - A request accepted at edge k into an empty, idle block drives BEAT0 from edge k+2.
//   - BEAT0: tsof_n=0, tsrc_rdy_n=0, teof_n=1, trem_n=00, td={DW0,DW1}.
//     Moves to BEAT1 on the edge where tdst_rdy_n=0.
//   - BEAT1: tsof_n=1, teof_n=0, tsrc_rdy_n=0, td={DW2,DATA}; DATA=req_data (CplD) or 0 (UR).
//     trem_n=8'h00 for CplD, 8'h0F for UR.
//     On tdst_rdy_n=0: pop FIFO, cpl_done=1 for one cycle, go to IDLE.
//   - While tdst_rdy_n=1, td/trem_n/sof/eof hold stable.
//   - Minimum 3 cycles per TLP.
//  Header fields:
//   - DW0 = {1'b0, fmt, type, 1'b0, tc, 4'b0, 2'b00, attr, 2'b00, len}.
//     fmt/type: CplD = 2'b10/5'b01010, len=1; UR = 2'b00/5'b01010, len=0.
//   - DW1 = {bus, dev, func, status, 1'b0, byte_count}; status 3'b000 for CplD, 3'b001 for UR.
//   - DW2 = {req_id, tag, 1'b0, lower_addr}.
//  Discontinue:
//   - trn_tdst_dsc_n=0 in BEAT0 or BEAT1 takes precedence over tdst_rdy_n.
//   - Action: deassert all framing next cycle, pop entry, go to IDLE, dsc_count+1 (stick at 255); no cpl_done.
//  Link down:
//   - trn_lnk_up_n=1 in any state: next cycle FSM=IDLE, framing deasserted, FIFO flushed.
//   - No cpl_done; dsc_count unchanged.
//  Reset mid-packet: same as link down, plus dsc_count cleared.
// TESTING
//  - Push req_id=16'h0100, tag=8'h05, tc=0, attr=0, lower_addr=7'h04, bc=12'h004, data=32'hDEADBEEF; bus=1, dev=0, func=0; tdst_rdy_n=0, tbuf_av=4'hF.
//    -> beat0 td=64'h4A000001_01000004; beat1 td=64'h01000504_DEADBEEF, trem_n=8'h00; cpl_done pulses once.
//  - Same request with req_ur=1.
//    -> beat0 td=64'h0A000000_01002004; beat1 upper DW=32'h01000504, trem_n=8'h0F.
//  - Hold tdst_rdy_n=1 for 5 cycles in BEAT0 and 3 cycles in BEAT1 -> td/sof/eof stable; exactly one TLP sent.
//  - tbuf_av[2]=0 with 4 queued requests.
//    -> no tsrc_rdy_n; req_ready=0 at 4 entries. Raise the bit -> 4 TLPs in order, with gaps >=1 cycle.
//  - Assert tdst_dsc_n=0 in BEAT1 -> framing drops, dsc_count=1, next entry sent; 300 discontinues -> dsc_count=255.
//  - Link down mid-BEAT0 with 3 queued -> IDLE, FIFO empty, no cpl_done; link up plus new request -> normal TLP.

Source files
------------

// File: rtl/trn_cpl_tx_if.sv
// Request-side and TRN-transmit signal bundle of the completion responder.
// Handshake: a request transfers on the rising edge where req_valid && req_ready; a TRN beat
// transfers on the edge where !trn_tsrc_rdy_n && !trn_tdst_rdy_n, unless trn_tdst_dsc_n is low.
interface trn_cpl_tx_if;
   logic        req_valid;
   logic        req_ready;
   logic [47:0] req_info;
   logic        req_ur;
   logic [31:0] req_data;
   logic [63:0] trn_td;
   logic [7:0]  trn_trem_n;
   logic        trn_tsof_n;
   logic        trn_teof_n;
   logic        trn_tsrc_rdy_n;
   logic        trn_tsrc_dsc_n;
   logic        trn_terrfwd_n;
   logic        trn_tdst_rdy_n;
   logic        trn_tdst_dsc_n;
   logic [3:0]  trn_tbuf_av;

   modport master (
      input  req_valid, req_info, req_ur, req_data,
      output req_ready,
      output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n, trn_terrfwd_n,
      input  trn_tdst_rdy_n, trn_tdst_dsc_n, trn_tbuf_av
   );

   modport slave (
      output req_valid, req_info, req_ur, req_data,
      input  req_ready,
      input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n, trn_terrfwd_n,
      output trn_tdst_rdy_n, trn_tdst_dsc_n, trn_tbuf_av
   );
endinterface

// File: rtl/trn_cpl_tx.sv
// Completion responder: queues 1-DW read responses and frames each as a 3DW CplD
// (or UR Cpl) TLP over two 64-bit TRN beats.
module trn_cpl_tx #(
   parameter int DEPTH = 4
) (
   input  logic        trn_clk,
   input  logic        trn_reset_n,
   input  logic        trn_lnk_up_n,
   input  logic [7:0]  cfg_bus_number,
   input  logic [4:0]  cfg_device_number,
   input  logic [2:0]  cfg_function_number,
   trn_cpl_tx_if.master bus,
   output logic        cpl_done,
   output logic [7:0]  dsc_count,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_BEAT0 = 2'b01,
      S_BEAT1 = 2'b10
   } state_t;

   state_t        state, state_next;
   logic [47:0]   info_mem [DEPTH];
   logic          ur_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          avail_q;
   logic          full, empty, push, pop, dsc_hit, done_d;
   logic [47:0]   head_info;
   logic          head_ur;
   logic [31:0]   head_data;
   logic [31:0]   dw0, dw1, dw2;
   logic [63:0]   td_d;
   logic [7:0]    trem_d;
   logic          tsof_d, teof_d, tsrc_d;
   logic          unused_tbuf;

   assign full          = (count == CNT_FULL);
   assign empty         = (count == '0);
   assign bus.req_ready = trn_reset_n && !full && !trn_lnk_up_n;
   assign push          = bus.req_valid && bus.req_ready;
   assign unused_tbuf   = ^{bus.trn_tbuf_av[3], bus.trn_tbuf_av[1:0]};
   assign dbg_state     = state;

   assign bus.trn_tsrc_dsc_n = 1'b1;
   assign bus.trn_terrfwd_n  = 1'b1;

   always_ff @(posedge trn_clk) begin
      if (push) begin
         info_mem[wr_ptr] <= bus.req_info;
         ur_mem[wr_ptr]   <= bus.req_ur;
         data_mem[wr_ptr] <= bus.req_data;
      end
   end

   // Link loss flushes the queue just like reset does.
   // avail_q lags the occupancy by one edge so a fresh entry launches two edges after its push.
   always_ff @(posedge trn_clk) begin
      if (!trn_reset_n || trn_lnk_up_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         avail_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         avail_q <= !empty;
      end
   end

   always_ff @(posedge trn_clk) begin
      if (!trn_reset_n) state <= S_IDLE;
      else              state <= state_next;
   end

   // Discontinue outranks destination-ready in either beat.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      dsc_hit    = 1'b0;
      done_d     = 1'b0;
      if (trn_lnk_up_n) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (avail_q && !empty && bus.trn_tbuf_av[2]) state_next = S_BEAT0;
            end
            S_BEAT0: begin
               if (!bus.trn_tdst_dsc_n) begin
                  state_next = S_IDLE;
                  pop        = 1'b1;
                  dsc_hit    = 1'b1;
               end else if (!bus.trn_tdst_rdy_n) begin
                  state_next = S_BEAT1;
               end
            end
            S_BEAT1: begin
               if (!bus.trn_tdst_dsc_n) begin
                  state_next = S_IDLE;
                  pop        = 1'b1;
                  dsc_hit    = 1'b1;
               end else if (!bus.trn_tdst_rdy_n) begin
                  state_next = S_IDLE;
                  pop        = 1'b1;
                  done_d     = 1'b1;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      head_info = info_mem[rd_ptr];
      head_ur   = ur_mem[rd_ptr];
      head_data = data_mem[rd_ptr];
      dw0 = {1'b0, (head_ur ? 2'b00 : 2'b10), 5'b01010, 1'b0, head_info[23:21], 4'b0000,
             2'b00, head_info[20:19], 2'b00, (head_ur ? 10'd0 : 10'd1)};
      dw1 = {cfg_bus_number, cfg_device_number, cfg_function_number,
             (head_ur ? 3'b001 : 3'b000), 1'b0, head_info[11:0]};
      dw2 = {head_info[47:32], head_info[31:24], 1'b0, head_info[18:12]};
   end

   // Outputs are decoded from the next state and registered, so they line up with the state.
   always_comb begin
      tsof_d = 1'b1;
      teof_d = 1'b1;
      tsrc_d = 1'b1;
      td_d   = '0;
      trem_d = 8'hFF;
      case (state_next)
         S_BEAT0: begin
            tsof_d = 1'b0;
            tsrc_d = 1'b0;
            td_d   = {dw0, dw1};
            trem_d = 8'h00;
         end
         S_BEAT1: begin
            teof_d = 1'b0;
            tsrc_d = 1'b0;
            td_d   = {dw2, (head_ur ? 32'h0 : head_data)};
            trem_d = head_ur ? 8'h0F : 8'h00;
         end
         default: ;
      endcase
   end

   always_ff @(posedge trn_clk) begin
      if (!trn_reset_n) begin
         bus.trn_td         <= '0;
         bus.trn_trem_n     <= 8'hFF;
         bus.trn_tsof_n     <= 1'b1;
         bus.trn_teof_n     <= 1'b1;
         bus.trn_tsrc_rdy_n <= 1'b1;
         cpl_done           <= 1'b0;
         dsc_count          <= '0;
      end else begin
         bus.trn_td         <= td_d;
         bus.trn_trem_n     <= trem_d;
         bus.trn_tsof_n     <= tsof_d;
         bus.trn_teof_n     <= teof_d;
         bus.trn_tsrc_rdy_n <= tsrc_d;
         cpl_done           <= done_d;
         if (dsc_hit && dsc_count != 8'hFF) dsc_count <= dsc_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_trn_cpl_tx.sv
// Bench for trn_cpl_tx: directed framing cases plus randomized traffic checked
// against a TLP-level reference model and scoreboard.
module tb_trn_cpl_tx;

   logic       trn_clk = 1'b0;
   logic       trn_reset_n;
   logic       trn_lnk_up_n;
   logic [7:0] cfg_bus_number;
   logic [4:0] cfg_device_number;
   logic [2:0] cfg_function_number;
   logic       cpl_done;
   logic [7:0] dsc_count;
   logic [1:0] dbg_state;

   trn_cpl_tx_if bus ();

   trn_cpl_tx #(.DEPTH(4)) dut (
      .trn_clk             (trn_clk),
      .trn_reset_n         (trn_reset_n),
      .trn_lnk_up_n        (trn_lnk_up_n),
      .cfg_bus_number      (cfg_bus_number),
      .cfg_device_number   (cfg_device_number),
      .cfg_function_number (cfg_function_number),
      .bus                 (bus),
      .cpl_done            (cpl_done),
      .dsc_count           (dsc_count),
      .dbg_state           (dbg_state)
   );

   always #5 trn_clk = ~trn_clk;

   int n_checks = 0;
   int n_errors = 0;
   int cpl_seen = 0;
   int exp_cpl  = 0;
   int exp_dsc  = 0;
   int gap_viol = 0;
   logic [135:0] exp_q[$];
   logic [135:0] got_q[$];
   logic [63:0]  mon_b0;
   logic         mon_have = 1'b0;
   logic         mon_eof  = 1'b0;

   // Expected TLP as {beat0 td, beat1 td, beat1 trem_n}, built from the header field rules.
   function automatic logic [135:0] model_tlp(input logic [47:0] info, input logic ur,
                                              input logic [31:0] data);
      logic [15:0] req_id;
      logic [7:0]  tag;
      logic [2:0]  tc;
      logic [1:0]  attr;
      logic [6:0]  la;
      logic [11:0] bc;
      logic [31:0] d0, d1, d2;
      {req_id, tag, tc, attr, la, bc} = info;
      if (ur) d0 = {1'b0, 2'b00, 5'b01010, 1'b0, tc, 4'h0, 2'b00, attr, 2'b00, 10'd0};
      else    d0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'h0, 2'b00, attr, 2'b00, 10'd1};
      d1 = {cfg_bus_number, cfg_device_number, cfg_function_number, (ur ? 3'b001 : 3'b000), 1'b0, bc};
      d2 = {req_id, tag, 1'b0, la};
      return {d0, d1, d2, (ur ? 32'h0 : data), (ur ? 8'h0F : 8'h00)};
   endfunction

   task automatic tick();
      @(posedge trn_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_req(input logic [47:0] info, input logic ur, input logic [31:0] data,
                           input bit expect_tlp);
      int  i;
      bit  ok;
      bus.req_valid = 1'b1;
      bus.req_info  = info;
      bus.req_ur    = ur;
      bus.req_data  = data;
      ok = 1'b0;
      for (i = 0; i < 100; i++) begin
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      bus.req_valid = 1'b0;
      check("push_accept", ok, 1'b1);
      if (ok && expect_tlp) begin
         exp_q.push_back(model_tlp(info, ur, data));
         exp_cpl++;
      end
   endtask

   task automatic rand_push(input bit expect_tlp);
      push_req({16'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), $urandom, expect_tlp);
   endtask

   task automatic wait_frame(input bit want_eof, input string tag);
      int i;
      for (i = 0; i < 50; i++) begin
         if (!bus.trn_tsrc_rdy_n && (want_eof ? !bus.trn_teof_n : !bus.trn_tsof_n)) break;
         tick();
      end
      check(tag, (i < 50), 1'b1);
   endtask

   task automatic drain(input bit rand_bp);
      int i;
      for (i = 0; i < 2000; i++) begin
         if (got_q.size() >= exp_q.size() && bus.trn_tsrc_rdy_n) break;
         bus.trn_tdst_rdy_n = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
      end
      bus.trn_tdst_rdy_n = 1'b0;
      tick();
      tick();
      check("drain_budget", (i < 2000), 1'b1);
      check("sb_count", got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) check("sb_tlp", got_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      got_q.delete();
      check("cpl_count", cpl_seen, exp_cpl);
   endtask

   // Beat monitor: a beat transfers at the next rising edge when sampled ready on both sides.
   always @(negedge trn_clk) begin
      if (cpl_done) cpl_seen++;
      if (!trn_reset_n || trn_lnk_up_n) begin
         mon_have = 1'b0;
         mon_eof  = 1'b0;
      end else begin
         if (mon_eof && !bus.trn_tsrc_rdy_n) gap_viol++;
         mon_eof = 1'b0;
         if (!bus.trn_tdst_dsc_n) begin
            mon_have = 1'b0;
         end else if (!bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n) begin
            if (!bus.trn_tsof_n) begin
               mon_b0   = bus.trn_td;
               mon_have = 1'b1;
            end else if (!bus.trn_teof_n && mon_have) begin
               got_q.push_back({mon_b0, bus.trn_td, bus.trn_trem_n});
               mon_have = 1'b0;
               mon_eof  = 1'b1;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] dir_info;
      logic [74:0] snap;
      bit          saw;

      trn_reset_n         = 1'b0;
      trn_lnk_up_n        = 1'b0;
      cfg_bus_number      = 8'd1;
      cfg_device_number   = 5'd0;
      cfg_function_number = 3'd0;
      bus.req_valid       = 1'b0;
      bus.req_info        = '0;
      bus.req_ur          = 1'b0;
      bus.req_data        = '0;
      bus.trn_tdst_rdy_n  = 1'b0;
      bus.trn_tdst_dsc_n  = 1'b1;
      bus.trn_tbuf_av     = 4'hF;

      // Reset values
      repeat (3) tick();
      check("rst_req_ready", bus.req_ready, 1'b0);
      trn_reset_n = 1'b1;
      check("rst_framing", {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n, bus.trn_tsrc_dsc_n,
                            bus.trn_terrfwd_n}, 5'b11111);
      check("rst_td", bus.trn_td, 64'h0);
      check("rst_trem", bus.trn_trem_n, 8'hFF);
      check("rst_cpl_dsc", {cpl_done, dsc_count}, 9'h0);
      tick();
      check("ready_after_rst", bus.req_ready, 1'b1);

      // Directed CplD: fixed two-edge launch latency and exact wire values
      dir_info = {16'h0100, 8'h05, 3'd0, 2'd0, 7'h04, 12'h004};
      push_req(dir_info, 1'b0, 32'hDEADBEEF, 1'b1);
      check("lat_k1", bus.trn_tsrc_rdy_n, 1'b1);
      tick();
      check("lat_k2", bus.trn_tsrc_rdy_n, 1'b1);
      tick();
      check("cpld_b0_td", bus.trn_td, 64'h4A000001_01000004);
      check("cpld_b0_ctl", {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n, bus.trn_trem_n},
            {1'b0, 1'b1, 1'b0, 8'h00});
      tick();
      check("cpld_b1_td", bus.trn_td, 64'h01000504_DEADBEEF);
      check("cpld_b1_ctl", {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n, bus.trn_trem_n},
            {1'b1, 1'b0, 1'b0, 8'h00});
      tick();
      check("cpld_done", {cpl_done, bus.trn_tsrc_rdy_n}, 2'b11);
      tick();
      check("cpld_done_pulse", cpl_done, 1'b0);

      // Directed UR
      push_req(dir_info, 1'b1, 32'hDEADBEEF, 1'b1);
      tick();
      tick();
      check("ur_b0_td", bus.trn_td, 64'h0A000000_01002004);
      tick();
      check("ur_b1_td", bus.trn_td, 64'h01000504_00000000);
      check("ur_b1_trem", bus.trn_trem_n, 8'h0F);
      drain(1'b0);

      // Destination stall: beats hold stable
      bus.trn_tdst_rdy_n = 1'b1;
      rand_push(1'b1);
      wait_frame(1'b0, "stall_sof_wait");
      snap = {bus.trn_td, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n, bus.trn_trem_n};
      repeat (5) begin
         tick();
         check("stall_b0", {bus.trn_td, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n,
                            bus.trn_trem_n}, snap);
      end
      bus.trn_tdst_rdy_n = 1'b0;
      tick();
      bus.trn_tdst_rdy_n = 1'b1;
      snap = {bus.trn_td, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n, bus.trn_trem_n};
      check("stall_b1_eof", bus.trn_teof_n, 1'b0);
      repeat (3) begin
         tick();
         check("stall_b1", {bus.trn_td, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n,
                            bus.trn_trem_n}, snap);
      end
      drain(1'b0);

      // No completion credit: queue fills, nothing launched, then drains in order
      bus.trn_tbuf_av = 4'hB;
      repeat (4) rand_push(1'b1);
      check("full_ready", bus.req_ready, 1'b0);
      saw = 1'b0;
      repeat (6) begin
         if (!bus.trn_tsrc_rdy_n) saw = 1'b1;
         tick();
      end
      check("tbuf_hold", saw, 1'b0);
      bus.trn_tbuf_av = 4'hF;
      drain(1'b0);

      // Discontinue in BEAT1: first dropped, second sent
      push_req({16'h1234, 8'h11, 3'd2, 2'd1, 7'h10, 12'h004}, 1'b0, 32'h0BAD_F00D, 1'b0);
      rand_push(1'b1);
      wait_frame(1'b1, "dsc_eof_wait");
      bus.trn_tdst_dsc_n = 1'b0;
      tick();
      bus.trn_tdst_dsc_n = 1'b1;
      exp_dsc = 1;
      check("dsc_framing", {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}, 3'b111);
      check("dsc_count_1", dsc_count, exp_dsc);
      drain(1'b0);

      // Discontinue saturation over 300 events, random beat
      for (int n = 2; n <= 300; n++) begin
         rand_push(1'b0);
         wait_frame(1'b0, "dsc_sof_wait");
         if ($urandom_range(0, 1) == 1) tick();
         bus.trn_tdst_dsc_n = 1'b0;
         tick();
         bus.trn_tdst_dsc_n = 1'b1;
         exp_dsc = (exp_dsc < 255) ? exp_dsc + 1 : 255;
         if (n == 100 || n == 255 || n == 256) check("dsc_count_mid", dsc_count, exp_dsc);
      end
      check("dsc_count_sat", dsc_count, exp_dsc);
      drain(1'b0);

      // Link down while stalled in BEAT0 with three queued
      bus.trn_tdst_rdy_n = 1'b1;
      repeat (3) rand_push(1'b0);
      wait_frame(1'b0, "lnk_sof_wait");
      trn_lnk_up_n = 1'b1;
      tick();
      check("lnk_framing", {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}, 3'b111);
      check("lnk_ready", bus.req_ready, 1'b0);
      tick();
      trn_lnk_up_n       = 1'b0;
      bus.trn_tdst_rdy_n = 1'b0;
      saw = 1'b0;
      repeat (4) begin
         tick();
         if (!bus.trn_tsrc_rdy_n) saw = 1'b1;
      end
      check("lnk_flushed", {saw, bus.req_ready}, 2'b01);
      check("lnk_dsc_kept", dsc_count, exp_dsc);
      rand_push(1'b1);
      drain(1'b0);

      // Randomized traffic with random destination backpressure
      for (int b = 0; b < 12; b++) begin
         cfg_bus_number      = 8'($urandom);
         cfg_device_number   = 5'($urandom);
         cfg_function_number = 3'($urandom);
         repeat ($urandom_range(1, 4)) rand_push(1'b1);
         drain(1'b1);
      end

      // Reset mid-packet clears the discontinue count and framing
      bus.trn_tdst_rdy_n = 1'b1;
      rand_push(1'b0);
      wait_frame(1'b0, "rst_sof_wait");
      bus.trn_tdst_rdy_n = 1'b0;
      tick();
      trn_reset_n = 1'b0;
      tick();
      trn_reset_n = 1'b1;
      check("midrst_framing", {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}, 3'b111);
      check("midrst_dsc", dsc_count, 8'd0);
      tick();
      saw = 1'b0;
      repeat (4) begin
         if (!bus.trn_tsrc_rdy_n) saw = 1'b1;
         tick();
      end
      check("midrst_flushed", saw, 1'b0);
      rand_push(1'b1);
      drain(1'b0);

      check("gap_between_tlps", gap_viol, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
